// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: aligns EX/MEM accesses onto a ready/valid
// data-memory port, stalls until completion and extends load results.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] rdata,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [31:0] rdata_q;
   logic        fault_q;
   logic [1:0]  cause_q;

   logic [1:0]  off;
   logic        act;
   logic        illegal;
   logic        misal;
   logic        start;
   logic        flt_now;
   logic [3:0]  be_n;
   logic [31:0] wd_n;
   logic [31:0] sh;
   logic [31:0] ext;

   // Outputs are forced quiet while reset is held, even with req_valid up.
   assign act = req_valid & reset;
   assign off = req_addr[1:0];

   always_comb begin
      illegal = 1'b0;
      if (req_we)
         illegal = (req_funct3 > 3'd2);
      else
         illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
      misal = 1'b0;
      case (req_funct3[1:0])
         2'b01:   misal = off[0];
         2'b10:   misal = (off != 2'b00);
         default: misal = 1'b0;
      endcase
   end

   always_comb begin
      be_n = 4'b1111;
      wd_n = req_wdata;
      if (req_we) begin
         case (req_funct3[1:0])
            2'b00: begin
               be_n = 4'b0001 << off;
               wd_n = {4{req_wdata[7:0]}};
            end
            2'b01: begin
               be_n = 4'b0011 << off;
               wd_n = {2{req_wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   assign start   = (state == IDLE) & act & ~illegal & ~misal;
   assign flt_now = (state == IDLE) & act & (illegal | misal);

   always_comb begin
      sh  = mem_rdata >> {off_q, 3'b000};
      ext = sh;
      case (f3_q)
         3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
         3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
         3'b100:  ext = {24'b0, sh[7:0]};
         3'b101:  ext = {16'b0, sh[15:0]};
         default: ext = sh;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         f3_q      <= '0;
         off_q     <= '0;
         rdata_q   <= '0;
         fault_q   <= 1'b0;
         cause_q   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= BUSY;
                  cnt       <= '0;
                  f3_q      <= req_funct3;
                  off_q     <= off;
                  mem_req   <= 1'b1;
                  mem_we    <= req_we;
                  mem_addr  <= {req_addr[31:2], 2'b00};
                  mem_be    <= be_n;
                  mem_wdata <= wd_n;
               end
            end
            BUSY: begin
               // A ready arriving on the last allowed cycle still wins.
               if (mem_ready) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  rdata_q <= mem_we ? 32'h0 : ext;
                  fault_q <= 1'b0;
                  cause_q <= 2'd0;
               end else if (cnt == TLAST) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  rdata_q <= '0;
                  fault_q <= 1'b1;
                  cause_q <= 2'd3;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               state   <= IDLE;
               rdata_q <= '0;
               fault_q <= 1'b0;
               cause_q <= 2'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign stall      = start | (state == BUSY);
   assign resp_valid = (state == DONE) | flt_now;
   assign rdata      = (state == DONE) ? rdata_q : 32'h0;
   assign fault      = (state == DONE) ? fault_q : flt_now;

   always_comb begin
      fault_cause = 2'd0;
      if (state == DONE)
         fault_cause = cause_q;
      else if (flt_now)
         fault_cause = illegal ? 2'd2 : 2'd1;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small wait-state memory
// responder driven from the access task.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        fault;
   logic [1:0]  fault_cause;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   int          r_stalls;
   int          r_busy;
   logic [31:0] r_rdata;
   logic        r_fault;
   logic [1:0]  r_cause;
   logic [3:0]  r_be;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_we;
   logic        r_mreq_done;
   logic        r_stall_done;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(4)) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_we(req_we),
      .req_funct3(req_funct3),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .stall(stall),
      .resp_valid(resp_valid),
      .rdata(rdata),
      .fault(fault),
      .fault_cause(fault_cause),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_be(mem_be),
      .mem_wdata(mem_wdata),
      .mem_ready(mem_ready),
      .mem_rdata(mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // rdy_at = BUSY cycle (1-based) on which mem_ready is raised; 0 = never.
   task automatic access(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int rdy_at, input logic [31:0] word);
      bit got;
      got = 0;
      r_stalls = 0; r_busy = 0;
      r_be = '0; r_addr = '0; r_wdata = '0; r_we = 1'b0;
      r_rdata = '0; r_fault = 1'b0; r_cause = '0;
      r_mreq_done = 1'b0; r_stall_done = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3;
      req_addr = a; req_wdata = wd;
      mem_ready = 1'b0; mem_rdata = '0;
      for (int n = 0; n < 40 && !got; n++) begin
         #1;
         if (resp_valid) begin
            got = 1;
            r_rdata = rdata; r_fault = fault; r_cause = fault_cause;
            r_mreq_done = mem_req; r_stall_done = stall;
            req_valid = 1'b0; mem_ready = 1'b0;
         end else begin
            if (stall) r_stalls++;
            if (mem_req) begin
               r_busy++;
               r_be = mem_be; r_addr = mem_addr;
               r_wdata = mem_wdata; r_we = mem_we;
               mem_ready = (r_busy == rdy_at);
               mem_rdata = word;
            end
            @(negedge clk);
         end
      end
      check("resp_seen", 32'(got), 32'd1);
      if (!got) begin
         req_valid = 1'b0;
         mem_ready = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      #3;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_resp", 32'(resp_valid), 32'd0);
      check("rst_addr", mem_addr, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // LW with wait states: ready on 3rd BUSY cycle
      access(1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
      check("lw_stalls", r_stalls, 4);
      check("lw_addr", r_addr, 32'h100);
      check("lw_be", 32'(r_be), 32'hF);
      check("lw_we", 32'(r_we), 32'd0);
      check("lw_rdata", r_rdata, 32'hDEADBEEF);
      check("lw_fault", 32'(r_fault), 32'd0);
      check("lw_mreq_done", 32'(r_mreq_done), 32'd0);
      check("lw_stall_done", 32'(r_stall_done), 32'd0);

      // Zero-wait latency and extension
      access(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF1234);
      check("lb_stalls", r_stalls, 2);
      check("lb_rdata", r_rdata, 32'hFFFFFF80);
      access(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF1234);
      check("lbu_rdata", r_rdata, 32'h00000080);
      access(1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF1234);
      check("lh_rdata", r_rdata, 32'hFFFF80FF);
      check("lh_addr", r_addr, 32'h100);
      access(1'b0, 3'b101, 32'h102, 32'h0, 2, 32'h80FF1234);
      check("lhu_rdata", r_rdata, 32'h000080FF);
      access(1'b0, 3'b000, 32'h101, 32'h0, 1, 32'h80FF1234);
      check("lb1_rdata", r_rdata, 32'h00000012);

      // Store lanes
      access(1'b1, 3'b000, 32'h201, 32'h000000AB, 1, 32'h0);
      check("sb_addr", r_addr, 32'h200);
      check("sb_be", 32'(r_be), 32'b0010);
      check("sb_wdata", r_wdata, 32'hABABABAB);
      check("sb_we", 32'(r_we), 32'd1);
      check("sb_rdata", r_rdata, 32'h0);
      access(1'b1, 3'b001, 32'h202, 32'h00001234, 1, 32'h0);
      check("sh_be", 32'(r_be), 32'b1100);
      check("sh_wdata", r_wdata, 32'h12341234);

      // Misaligned and illegal
      access(1'b0, 3'b010, 32'h102, 32'h0, 1, 32'h0);
      check("mis_busy", r_busy, 0);
      check("mis_stalls", r_stalls, 0);
      check("mis_fault", 32'(r_fault), 32'd1);
      check("mis_cause", 32'(r_cause), 32'd1);
      access(1'b0, 3'b001, 32'h101, 32'h0, 1, 32'h0);
      check("mis_lh_cause", 32'(r_cause), 32'd1);
      access(1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h0);
      check("ill_ld_busy", r_busy, 0);
      check("ill_ld_cause", 32'(r_cause), 32'd2);
      access(1'b1, 3'b100, 32'h100, 32'h0, 1, 32'h0);
      check("ill_st_cause", 32'(r_cause), 32'd2);
      access(1'b0, 3'b111, 32'h101, 32'h0, 1, 32'h0);
      check("ill_prio_cause", 32'(r_cause), 32'd2);

      // Timeout with TIMEOUT=4
      access(1'b0, 3'b010, 32'h180, 32'h0, 0, 32'h12345678);
      check("to_busy", r_busy, 4);
      check("to_fault", 32'(r_fault), 32'd1);
      check("to_cause", 32'(r_cause), 32'd3);
      check("to_rdata", r_rdata, 32'h0);
      check("to_mreq_done", 32'(r_mreq_done), 32'd0);
      check("to_stall_done", 32'(r_stall_done), 32'd0);

      // Ready on the final allowed cycle resolves as success
      access(1'b0, 3'b010, 32'h184, 32'h0, 4, 32'h0BADF00D);
      check("edge_fault", 32'(r_fault), 32'd0);
      check("edge_rdata", r_rdata, 32'h0BADF00D);

      // Reset while BUSY
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h400; mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("pre_rst_req", 32'(mem_req), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst_req", 32'(mem_req), 32'd0);
      check("mid_rst_stall", 32'(stall), 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      access(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 1, 32'h0);
      check("post_sw_be", 32'(r_be), 32'hF);
      check("post_sw_addr", r_addr, 32'h300);
      check("post_sw_wdata", r_wdata, 32'hCAFEF00D);
      check("post_sw_fault", 32'(r_fault), 32'd0);
      check("post_sw_stalls", r_stalls, 2);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
